// File: rtl/choice_1ofn_mon.sv
// Registered 1-of-N code monitor: validity, index, sticky error, saturating error counter.
// Define CHOICE_CAPTURE_EN to add the first-error capture (cap_valid / cap_x).
module choice_1ofn_mon #(
  parameter int unsigned N          = 5,
  parameter int unsigned IDX_W      = $clog2(N),
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned ALLOW_ZERO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     x,
  input  logic             clr,
  output logic             out_valid,
  output logic             y,
  output logic [IDX_W-1:0] idx,
  output logic             err_zero,
  output logic             err_multi,
  output logic             err_sticky,
`ifdef CHOICE_CAPTURE_EN
  output logic             cap_valid,
  output logic [N-1:0]     cap_x,
`endif
  output logic [CNT_W-1:0] err_cnt
);

  logic             out_valid_q, y_q, err_zero_q, err_multi_q, err_sticky_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic             out_valid_d, y_d, err_zero_d, err_multi_d, err_sticky_d;
  logic [IDX_W-1:0] idx_d;
  logic [CNT_W-1:0] err_cnt_d;

  logic             seen, multi, zero, err_d, sticky_base;
  logic [IDX_W-1:0] idx_raw;
  logic [CNT_W-1:0] cnt_base;

`ifdef CHOICE_CAPTURE_EN
  logic             cap_valid_q, cap_valid_d, cap_base;
  logic [N-1:0]     cap_x_q, cap_x_d;
`endif

  // Serial "seen one already" chain: multi is set exactly when popcount >= 2.
  always_comb begin
    seen    = 1'b0;
    multi   = 1'b0;
    idx_raw = '0;
    for (int unsigned i = 0; i < N; i++) begin
      multi = multi | (seen & x[i]);
      seen  = seen | x[i];
      if (x[i]) idx_raw = idx_raw | IDX_W'(i);
    end
    zero = ~seen;
  end

  always_comb begin
    out_valid_d = in_valid;
    err_zero_d  = in_valid & zero & (ALLOW_ZERO == 0);
    err_multi_d = in_valid & multi;
    err_d       = err_zero_d | err_multi_d;
    y_d         = in_valid & ~err_d;
    // idx_raw is only meaningful for a single set bit.
    idx_d       = (in_valid & ~multi & ~zero) ? idx_raw : '0;

    // Clear is applied before the current sample is recorded.
    sticky_base  = clr ? 1'b0 : err_sticky_q;
    cnt_base     = clr ? '0 : err_cnt_q;
    err_sticky_d = sticky_base | err_d;
    err_cnt_d    = (err_d && (cnt_base != '1)) ? cnt_base + CNT_W'(1) : cnt_base;

`ifdef CHOICE_CAPTURE_EN
    cap_base    = clr ? 1'b0 : cap_valid_q;
    cap_valid_d = cap_base | err_d;
    cap_x_d     = clr ? '0 : cap_x_q;
    if (err_d && !cap_base) cap_x_d = x;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      y_q          <= 1'b0;
      idx_q        <= '0;
      err_zero_q   <= 1'b0;
      err_multi_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
`ifdef CHOICE_CAPTURE_EN
      cap_valid_q  <= 1'b0;
      cap_x_q      <= '0;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      y_q          <= y_d;
      idx_q        <= idx_d;
      err_zero_q   <= err_zero_d;
      err_multi_q  <= err_multi_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
`ifdef CHOICE_CAPTURE_EN
      cap_valid_q  <= cap_valid_d;
      cap_x_q      <= cap_x_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign y          = y_q;
  assign idx        = idx_q;
  assign err_zero   = err_zero_q;
  assign err_multi  = err_multi_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
`ifdef CHOICE_CAPTURE_EN
  assign cap_valid  = cap_valid_q;
  assign cap_x      = cap_x_q;
`endif

endmodule

// File: tb/tb_choice_1ofn_mon.sv
// Bench for choice_1ofn_mon: two instances (strict / zero-allowed with 2-bit counter)
// against a popcount-based reference model, plus directed literal checks.
module tb_choice_1ofn_mon;

  localparam int unsigned N = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic clr = 1'b0;
  logic [N-1:0] x = '0;

  logic ov0, y0, ez0, em0, st0;
  logic ov1, y1, ez1, em1, st1;
  logic [2:0] idx0, idx1;
  logic [2:0] cnt0;
  logic [1:0] cnt1;
`ifdef CHOICE_CAPTURE_EN
  logic cv0, cv1;
  logic [N-1:0] cx0, cx1;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  choice_1ofn_mon #(.N(N), .CNT_W(3), .ALLOW_ZERO(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .clr(clr),
    .out_valid(ov0), .y(y0), .idx(idx0), .err_zero(ez0), .err_multi(em0),
    .err_sticky(st0),
`ifdef CHOICE_CAPTURE_EN
    .cap_valid(cv0), .cap_x(cx0),
`endif
    .err_cnt(cnt0)
  );

  choice_1ofn_mon #(.N(N), .CNT_W(2), .ALLOW_ZERO(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .clr(clr),
    .out_valid(ov1), .y(y1), .idx(idx1), .err_zero(ez1), .err_multi(em1),
    .err_sticky(st1),
`ifdef CHOICE_CAPTURE_EN
    .cap_valid(cv1), .cap_x(cx1),
`endif
    .err_cnt(cnt1)
  );

  // Reference model, per instance k: 0 = strict/CNT_W=3, 1 = zero allowed/CNT_W=2.
  int m_ov = 0;
  int m_y[2] = '{0, 0};
  int m_idx[2] = '{0, 0};
  int m_ez[2] = '{0, 0};
  int m_em[2] = '{0, 0};
  int m_st[2] = '{0, 0};
  int m_cnt[2] = '{0, 0};
  int m_cv[2] = '{0, 0};
  int m_cx[2] = '{0, 0};

  function automatic int az_of(int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic int cmax_of(int k);
    return (k == 1) ? 3 : 7;
  endfunction

  function automatic int pos_of(logic [N-1:0] w);
    for (int i = 0; i < N; i++) if (w[i]) return i;
    return 0;
  endfunction

  function automatic int is_err(int k, logic v, logic [N-1:0] w);
    int p;
    p = $countones(w);
    return (v && ((p == 0 && az_of(k) == 0) || p >= 2)) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    m_ov <= (rst || !in_valid) ? 0 : 1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_y[k] <= 0; m_idx[k] <= 0; m_ez[k] <= 0; m_em[k] <= 0;
        m_st[k] <= 0; m_cnt[k] <= 0; m_cv[k] <= 0; m_cx[k] <= 0;
      end else begin
        m_y[k]   <= (in_valid && is_err(k, 1'b1, x) == 0) ? 1 : 0;
        m_idx[k] <= (in_valid && $countones(x) == 1) ? pos_of(x) : 0;
        m_ez[k]  <= (in_valid && $countones(x) == 0 && az_of(k) == 0) ? 1 : 0;
        m_em[k]  <= (in_valid && $countones(x) >= 2) ? 1 : 0;
        if (is_err(k, in_valid, x) != 0) begin
          m_st[k]  <= 1;
          m_cnt[k] <= clr ? 1 : ((m_cnt[k] < cmax_of(k)) ? m_cnt[k] + 1 : m_cnt[k]);
          if (clr || m_cv[k] == 0) begin
            m_cv[k] <= 1;
            m_cx[k] <= int'(x);
          end else if (clr) begin
            m_cx[k] <= 0;
          end
        end else if (clr) begin
          m_st[k] <= 0; m_cnt[k] <= 0; m_cv[k] <= 0; m_cx[k] <= 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ov0", 32'(ov0), m_ov);
      chk("ov1", 32'(ov1), m_ov);
      chk("y0", 32'(y0), m_y[0]);
      chk("y1", 32'(y1), m_y[1]);
      chk("idx0", 32'(idx0), m_idx[0]);
      chk("idx1", 32'(idx1), m_idx[1]);
      chk("ez0", 32'(ez0), m_ez[0]);
      chk("ez1", 32'(ez1), m_ez[1]);
      chk("em0", 32'(em0), m_em[0]);
      chk("em1", 32'(em1), m_em[1]);
      chk("st0", 32'(st0), m_st[0]);
      chk("st1", 32'(st1), m_st[1]);
      chk("cnt0", 32'(cnt0), m_cnt[0]);
      chk("cnt1", 32'(cnt1), m_cnt[1]);
`ifdef CHOICE_CAPTURE_EN
      chk("cv0", 32'(cv0), m_cv[0]);
      chk("cv1", 32'(cv1), m_cv[1]);
      chk("cx0", 32'(cx0), m_cx[0]);
      chk("cx1", 32'(cx1), m_cx[1]);
`endif
    end
  end

  // Caller is just after a rising edge; inputs apply to the next edge, results are read after it.
  task automatic step(input logic v, input logic [N-1:0] w, input logic c, input logic r);
    in_valid = v;
    x        = w;
    clr      = c;
    rst      = r;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [N-1:0] w;
    int sel;
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rst_ov", 32'(ov0), 0);
    chk("rst_cnt", 32'(cnt0), 0);

    // Walking one: idx follows the bit position, no errors.
    for (int i = 0; i < N; i++) begin
      step(1'b1, N'(1) << i, 1'b0, 1'b0);
      chk("walk_y", 32'(y0), 1);
      chk("walk_idx", 32'(idx0), i);
    end
    chk("walk_cnt", 32'(cnt0), 0);
    chk("walk_st", 32'(st0), 0);

    // Illegal words on the strict instance.
    step(1'b1, 5'b00000, 1'b0, 1'b0);
    chk("ill_ez", 32'(ez0), 1);
    chk("ill_y", 32'(y0), 0);
    step(1'b1, 5'b00101, 1'b0, 1'b0);
    chk("ill_em_a", 32'(em0), 1);
    chk("ill_ez_a", 32'(ez0), 0);
    step(1'b1, 5'b11111, 1'b0, 1'b0);
    chk("ill_em_b", 32'(em0), 1);
    chk("ill_cnt", 32'(cnt0), 3);
    chk("ill_st", 32'(st0), 1);
`ifdef CHOICE_CAPTURE_EN
    chk("ill_cv", 32'(cv0), 1);
    chk("ill_cx", 32'(cx0), 0);
`endif
    chk("az_cnt_pre", 32'(cnt1), 2);

    // Zero allowed as idle.
    step(1'b1, 5'b00000, 1'b0, 1'b0);
    chk("az_y", 32'(y1), 1);
    chk("az_idx", 32'(idx1), 0);
    chk("az_ez", 32'(ez1), 0);
    chk("az_cnt", 32'(cnt1), 2);

    // Saturation of the 2-bit counter.
    step(1'b0, '0, 1'b1, 1'b0);
    chk("clr_cnt", 32'(cnt1), 0);
    chk("clr_st", 32'(st1), 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 5'b00011, 1'b0, 1'b0);
      chk("sat_cnt", 32'(cnt1), (i < 3) ? i + 1 : 3);
    end
    chk("sat_st", 32'(st1), 1);

    // Clear colliding with an error.
    step(1'b1, 5'b00011, 1'b1, 1'b0);
    chk("col_cnt", 32'(cnt1), 1);
    chk("col_st", 32'(st1), 1);
`ifdef CHOICE_CAPTURE_EN
    chk("col_cx", 32'(cx1), 5'b00011);
`endif

    // Reset mid-stream drops the sample.
    step(1'b1, 5'b00110, 1'b0, 1'b1);
    chk("mrst_ov", 32'(ov0), 0);
    chk("mrst_em", 32'(em0), 0);
    chk("mrst_cnt", 32'(cnt0), 0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("mrst_ov_after", 32'(ov0), 0);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       w = N'(1) << $urandom_range(0, N - 1);
        1:       w = '0;
        2:       w = N'($urandom);
        default: w = (N'(1) << $urandom_range(0, 1)) | (N'(4) << $urandom_range(0, 2));
      endcase
      step($urandom_range(0, 3) != 0, w, $urandom_range(0, 31) == 0,
           $urandom_range(0, 99) == 0);
    end

    step(1'b0, '0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/choice_1ofn_mon.md
# choice_1ofn_mon

Registered, parametrised 1-of-N code monitor for N-wide choice/select buses. It samples a code word when `in_valid` is high and reports one cycle later whether the word is a legal one-hot code, together with the binary index of the set bit. It keeps sticky error status, a saturating error counter, and an optional capture of the first offending word. It sits on select/arbitration buses as a checker, with generalised width and with mode and statistics support.

## Interface
- `N`, 5: code width; legal range 2..32.
- `IDX_W`, `$clog2(N)`: index width; derived, not overridden.
- `CNT_W`, 8: error counter width; legal range 1..32.
- `ALLOW_ZERO`, 0: when 1, the all-zero word is legal (idle) and not an error.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  sample strobe for `x`.
- `x`  in  N  code word under test.
- `clr`  in  1  synchronous clear of sticky flags, the counter and the capture.
- `out_valid`  out  1  result strobe; `in_valid` delayed by one cycle.
- `y`  out  1  1 = sampled word is legal.
- `idx`  out  IDX_W  index of the set bit when `y`=1 and the word is nonzero; 0 otherwise.
- `err_zero`  out  1  sampled word was all-zero and `ALLOW_ZERO`=0; qualified by `out_valid`.
- `err_multi`  out  1  sampled word had two or more bits set; qualified by `out_valid`.
- `err_sticky`  out  1  set by any error; held until `clr` or `rst`.
- `err_cnt`  out  CNT_W  number of errored samples; saturates at all-ones.
- `cap_valid`  out  1  first-error capture holds a word (present only with `CHOICE_CAPTURE_EN`).
- `cap_x`  out  N  first errored word (present only with `CHOICE_CAPTURE_EN`).

## Operation
- Classification when `in_valid`=1, using popcount p of `x`:
  - p==1: legal. `y`=1 and `idx` = position of the set bit.
  - p==0: legal if `ALLOW_ZERO`=1, with `y`=1 and `idx`=0. Otherwise `err_zero`=1 and `y`=0.
  - p>=2: `err_multi`=1, `y`=0, `idx`=0.
- `err_zero` and `err_multi` are never both 1.
- When `in_valid`=0: `out_valid`, `y`, `err_zero` and `err_multi` go to 0 on the next edge. `idx` goes to 0. Statistics are unchanged.
- Errored sample: `err_sticky` is set, and `err_cnt` increments unless it is already all-ones.
- `clr` in the same cycle as an errored sample: the clear applies first, then the sample is recorded. Result: `err_cnt`=1, `err_sticky`=1, and the capture holds the new word.
- `clr` has no effect on the result path (`out_valid`, `y`, `idx`, `err_zero`, `err_multi`).
- The ones-check must be popcount-equivalent. Enumerating pairwise terms is acceptable only if every one of the N(N-1)/2 pairs is covered.

## Timing
- Latency: exactly one cycle from a sample edge to `out_valid`/`y`/`idx`/`err_*`. All outputs are registered.
- Throughput: one sample per cycle. Back-to-back `in_valid` is supported with no bubbles.
- Statistics outputs (`err_sticky`, `err_cnt`, `cap_*`) update on the same edge as the result outputs.
- Reset values (`rst`=1): all outputs are 0. This includes `out_valid`, `y`, `idx`, `err_zero`, `err_multi`, `err_sticky`, `err_cnt`, `cap_valid` and `cap_x`.
- Reset takes priority over `clr` and `in_valid`. A sample presented during `rst` is discarded and produces no `out_valid` afterwards.
- Counter wrap-around is forbidden. At all-ones, further errors leave `err_cnt` unchanged while `err_sticky` stays 1.

## Configuration
- `CHOICE_CAPTURE_EN` defined:
  - The `cap_valid` and `cap_x` ports and registers exist.
  - On the first errored sample while `cap_valid`=0, `cap_x` = `x` and `cap_valid`=1.
  - Later errors do not overwrite the capture.
  - `clr` or `rst` empties the capture.
- `CHOICE_CAPTURE_EN` undefined: the ports and registers are absent. All other behaviour is identical.

## Test plan
- Walking one, N=5, ALLOW_ZERO=0: `x`=00001..10000 on consecutive cycles → one cycle later `y`=1 with `idx`=0..4 in order. `err_cnt`=0 and `err_sticky`=0.
- Illegal words: `x`=00000, then 00101, then 11111 → `err_zero`=1; then `err_multi`=1; then `err_multi`=1. `err_cnt`=3, `err_sticky`=1. With the macro, `cap_x`=00000.
- `ALLOW_ZERO`=1: `x`=00000 → `y`=1, `idx`=0, no error flags, `err_cnt` unchanged.
- Saturation, CNT_W=2: five errored samples → `err_cnt` reads 1, 2, 3, 3, 3, and never returns to 0.
- Clear and error collide: with `err_cnt`=3, assert `clr` with `x`=00011 and `in_valid`=1 → `err_cnt`=1, `err_sticky`=1, `cap_x`=00011.
- Reset mid-stream: assert `rst` while `in_valid` is high with `x`=00110 → all outputs 0 on the next edge, and no `out_valid` pulse for that sample after reset is released.
